md_unit_iter: RTL and testbench
===============================

# md_unit_iter

Parametrised HI/LO multiply/divide unit for the pipelined MIPS core, the successor to the fixed-latency MD block. Sits beside the E-stage ALU and serves mult/multu/div/divu, mthi/mtlo and optional madd/maddu/msub/msubu. Division is a genuine radix-2 restoring iteration, not a delayed behavioural result. A cancel input aborts an in-flight operation on exception/flush.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4.
- MUL_CYCLES, 5: multiply-class latency in cycles; 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- w1  in  WIDTH  rs operand; also the mthi/mtlo data.
- w2  in  WIDTH  rt operand.
- op  in  4  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu; 9-15 none.
- start  in  1  launch op; sampled only when busy=0.
- hi_we  in  1  mthi: hi <= w1.
- lo_we  in  1  mtlo: lo <= w1.
- cancel  in  1  abort in-flight op.
- busy  out  1  operation in flight; the core stalls HI/LO consumers on it.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX. Reset (reset=0, any time, mid-op included) forces IDLE with hi=0, lo=0, busy=0, done=0, and clears counter and temporaries.
- Priority per edge: cancel > start > hi_we/lo_we. hi_we and lo_we together apply both.
- IDLE, start with valid op: operands latched, busy=1. Ops 0 and 9-15 do nothing. Ops 5-8 do nothing when the MADD feature is compiled out.
- IDLE, no start: hi_we/lo_we update hi/lo.
- While busy: start, hi_we and lo_we are ignored. The core guarantees it does not issue them.
- MUL: the full 2·WIDTH product (signed for 1/5/7, unsigned for 2/6/8) is registered at launch, then a counter runs MUL_CYCLES. The last edge commits {hi,lo} <= product for mult/multu. For madd it commits {hi,lo}+product; for msub it commits {hi,lo}−product. Arithmetic wraps mod 2^(2·WIDTH).
- DIV: operands are converted to magnitudes for div. WIDTH restoring iterations run, one quotient bit per cycle (shift remainder, trial subtract, keep if non-negative). FIX then applies signs: the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign. lo=quotient, hi=remainder.
- Divide by zero (div/divu): lo = all ones, hi = w1.
- Signed overflow (most-negative / −1): lo = most-negative, hi = 0. No exception is raised.
- cancel while busy: back to IDLE next edge; hi/lo unchanged; done not pulsed.
- cancel while idle: no effect.
- A start in the same cycle as a commit is impossible, because busy is still 1 in the commit cycle.

## Timing
- Start is sampled at edge E0. busy=1 from after E0.
- Multiply class: commit at edge E(MUL_CYCLES). busy is high for exactly MUL_CYCLES cycles. The new hi/lo and done=1 are visible after that edge.
- Divide class: WIDTH iteration edges plus 1 FIX edge give a latency of WIDTH+1 cycles (33 at WIDTH=32).
- busy falls on the same edge that commits hi/lo. A consumer unstalled by busy=0 reads the new value with no bypass.
- mthi/mtlo: hi/lo updated at the edge sampling hi_we/lo_we, so they are visible the next cycle.
- cancel: busy=0 after the edge sampling cancel. A new start is accepted the cycle after.

## Configuration
- MD_MADD_EN defined: ops 5-8 implemented as described, including the 2·WIDTH accumulate adder.
- MD_MADD_EN undefined: ops 5-8 are treated as op 0 (no launch, busy stays 0), and the accumulate adder is not synthesised.

## Test plan
- mult w1=0xFFFFFFFF, w2=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- divu 100/7 -> busy high 33 cycles, then lo=14, hi=2. div −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 5/0 -> lo=0xFFFFFFFF, hi=5. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0, mtlo 0xFFFFFFFF, then madd 1×1 -> hi=1, lo=0. Then msub 1×1 -> hi=0, lo=0xFFFFFFFF. Without MD_MADD_EN -> busy never rises, hi/lo unchanged.
- Start divu, then cancel in iteration cycle 10 -> busy=0 next cycle, hi/lo retain their pre-start values, no done. A following mult 3×4 gives lo=12, hi=0.
- Assert reset=0 asynchronously mid-div -> hi=lo=0 and busy=0 immediately without a clock edge. A start after reset release proceeds normally.

Source files
------------

// File: rtl/md_unit_iter_if.sv
// Core-side bundle for the HI/LO multiply/divide unit.
// Handshake: start is accepted only on an edge where busy=0; busy then stays high until the edge that commits HI/LO (or a cancel), and done pulses for one cycle after a commit.
interface md_unit_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] w2;
    logic [3:0]       op;
    logic             start;
    logic             hi_we;
    logic             lo_we;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output w1, w2, op, start, hi_we, lo_we, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  w1, w2, op, start, hi_we, lo_we, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit_iter.sv
// Iterative HI/LO multiply/divide unit: fixed-latency multiply, radix-2 restoring divide, cancel on flush.
// Define MD_MADD_EN to build madd/maddu/msub/msubu and the 2*WIDTH accumulate adder.
module md_unit_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic              clk,
    input  logic              reset,
    md_unit_iter_if.slave     md,
    output logic [1:0]        state_dbg
);

    localparam int W2   = 2 * WIDTH;
    localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r;
    logic [CW-1:0]    cnt;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] rem, quo, dvsr, dvd_raw;
    logic             sign_q, sign_r, div_zero;

    // Launch decode
    logic launch_mul, launch_div, mul_signed, div_signed;
`ifdef MD_MADD_EN
    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_SUB  = 2'd2;
    logic [1:0] acc_mode_d, acc_mode;
`endif

    always_comb begin
        launch_mul = 1'b0;
        launch_div = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
`ifdef MD_MADD_EN
        acc_mode_d = ACC_NONE;
`endif
        case (md.op)
            4'd1: begin launch_mul = 1'b1; mul_signed = 1'b1; end
            4'd2: launch_mul = 1'b1;
            4'd3: begin launch_div = 1'b1; div_signed = 1'b1; end
            4'd4: launch_div = 1'b1;
`ifdef MD_MADD_EN
            4'd5: begin launch_mul = 1'b1; mul_signed = 1'b1; acc_mode_d = ACC_ADD; end
            4'd6: begin launch_mul = 1'b1; acc_mode_d = ACC_ADD; end
            4'd7: begin launch_mul = 1'b1; mul_signed = 1'b1; acc_mode_d = ACC_SUB; end
            4'd8: begin launch_mul = 1'b1; acc_mode_d = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    // cancel outranks start, so a start in a cancel cycle is dropped
    logic accept, go_mul, go_div;
    assign accept = (state == S_IDLE) && md.start && !md.cancel;
    assign go_mul = accept && launch_mul;
    assign go_div = accept && launch_div;

    // One shared multiplier; sign- or zero-extension picks mult vs multu
    logic [W2-1:0] ext_a, ext_b, prod_d;
    assign ext_a  = mul_signed ? {{WIDTH{md.w1[WIDTH-1]}}, md.w1} : {{WIDTH{1'b0}}, md.w1};
    assign ext_b  = mul_signed ? {{WIDTH{md.w2[WIDTH-1]}}, md.w2} : {{WIDTH{1'b0}}, md.w2};
    assign prod_d = ext_a * ext_b;

    logic [WIDTH-1:0] mag_a, mag_b;
    assign mag_a = (div_signed && md.w1[WIDTH-1]) ? -md.w1 : md.w1;
    assign mag_b = (div_signed && md.w2[WIDTH-1]) ? -md.w2 : md.w2;

    logic [W2-1:0] mul_result;
    always_comb begin
        mul_result = prod;
`ifdef MD_MADD_EN
        case (acc_mode)
            ACC_ADD: mul_result = {hi_r, lo_r} + prod;
            ACC_SUB: mul_result = {hi_r, lo_r} - prod;
            default: mul_result = prod;
        endcase
`endif
    end

    // Restoring step: shift next dividend bit in, keep the subtraction if it did not borrow
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] rem_next, quo_next;
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up; most-negative / -1 falls out as quotient = most-negative, remainder = 0
    logic [WIDTH-1:0] quo_fix, rem_fix;
    always_comb begin
        if (div_zero) begin
            quo_fix = {WIDTH{1'b1}};
            rem_fix = dvd_raw;
        end else begin
            quo_fix = sign_q ? -quo : quo;
            rem_fix = sign_r ? -rem : rem;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (go_mul)      state_d = S_MUL;
                else if (go_div) state_d = S_DIV;
            end
            S_MUL:   if (md.cancel || cnt == '0) state_d = S_IDLE;
            S_DIV: begin
                if (md.cancel)      state_d = S_IDLE;
                else if (cnt == '0) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        md.busy   = (state != S_IDLE);
        md.done   = done_r;
        md.hi     = hi_r;
        md.lo     = lo_r;
        state_dbg = state;
    end

    // Datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
            cnt      <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            dvd_raw  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
`ifdef MD_MADD_EN
            acc_mode <= ACC_NONE;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_mul) begin
                        prod <= prod_d;
                        cnt  <= CW'(MUL_CYCLES - 1);
`ifdef MD_MADD_EN
                        acc_mode <= acc_mode_d;
`endif
                    end else if (go_div) begin
                        rem      <= '0;
                        quo      <= mag_a;
                        dvsr     <= mag_b;
                        dvd_raw  <= md.w1;
                        sign_q   <= div_signed && (md.w1[WIDTH-1] ^ md.w2[WIDTH-1]);
                        sign_r   <= div_signed && md.w1[WIDTH-1];
                        div_zero <= (md.w2 == '0);
                        cnt      <= CW'(WIDTH - 1);
                    end else if (!md.cancel && !md.start) begin
                        if (md.hi_we) hi_r <= md.w1;
                        if (md.lo_we) lo_r <= md.w1;
                    end
                end
                S_MUL: begin
                    if (!md.cancel) begin
                        if (cnt == '0) begin
                            {hi_r, lo_r} <= mul_result;
                            done_r       <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    if (!md.cancel) begin
                        rem <= rem_next;
                        quo <= quo_next;
                        if (cnt != '0) cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (!md.cancel) begin
                        lo_r   <= quo_fix;
                        hi_r   <= rem_fix;
                        done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_iter.sv
// Directed bench for md_unit_iter at WIDTH=32, MUL_CYCLES=5.
module tb_md_unit_iter;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         total = 0;
  int         bad   = 0;

  md_unit_iter_if #(.WIDTH(32)) bus ();

  md_unit_iter #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .md        (bus),
    .state_dbg (state_dbg)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic d1, output logic d2);
    bus.op = o; bus.w1 = a; bus.w2 = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.op = 4'd0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    d1 = bus.done;
    tick();
    d2 = bus.done;
  endtask

  task automatic write_hilo(input logic h, input logic l, input logic [31:0] v);
    bus.w1 = v; bus.hi_we = h; bus.lo_we = l;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_mthi_mtlo();
    write_hilo(1'b1, 1'b0, 32'hCAFE_0001);
    total++; if (bus.hi !== 32'hCAFE_0001) begin bad++; $display("FAIL mthi: got %h want %h", bus.hi, 32'hCAFE_0001); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL mthi_lo_kept: got %h want %h", bus.lo, 32'h0); end
    write_hilo(1'b1, 1'b1, 32'h5A5A_A5A5);
    total++; if (bus.hi !== 32'h5A5A_A5A5) begin bad++; $display("FAIL both_hi: got %h want %h", bus.hi, 32'h5A5A_A5A5); end
    total++; if (bus.lo !== 32'h5A5A_A5A5) begin bad++; $display("FAIL both_lo: got %h want %h", bus.lo, 32'h5A5A_A5A5); end
  endtask

  task automatic test_mult();
    int cyc; logic d1, d2;
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, cyc, d1, d2);
    total++; if (cyc !== 5) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
    total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want %h", bus.hi, 32'hFFFF_FFFF); end
    total++; if (bus.lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo: got %h want %h", bus.lo, 32'hFFFF_FFFE); end
    total++; if (d1 !== 1'b1) begin bad++; $display("FAIL mult_done: got %b want 1", d1); end
    total++; if (d2 !== 1'b0) begin bad++; $display("FAIL mult_done_once: got %b want 0", d2); end
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, cyc, d1, d2);
    total++; if (bus.hi !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi: got %h want %h", bus.hi, 32'h1); end
    total++; if (bus.lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo: got %h want %h", bus.lo, 32'hFFFF_FFFE); end
  endtask

  task automatic test_div();
    int cyc; logic d1, d2;
    run_op(4'd4, 32'd100, 32'd7, cyc, d1, d2);
    total++; if (cyc !== 33) begin bad++; $display("FAIL divu_busy_cycles: got %0d want 33", cyc); end
    total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL divu_lo: got %h want %h", bus.lo, 32'd14); end
    total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL divu_hi: got %h want %h", bus.hi, 32'd2); end
    total++; if (d1 !== 1'b1 || d2 !== 1'b0) begin bad++; $display("FAIL divu_done: got %b%b want 10", d1, d2); end
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc, d1, d2);
    total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo: got %h want %h", bus.lo, 32'hFFFF_FFFD); end
    total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi: got %h want %h", bus.hi, 32'hFFFF_FFFF); end
    run_op(4'd3, 32'd7, 32'hFFFF_FFFE, cyc, d1, d2);
    total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negdiv_lo: got %h want %h", bus.lo, 32'hFFFF_FFFD); end
    total++; if (bus.hi !== 32'd1) begin bad++; $display("FAIL div_negdiv_hi: got %h want %h", bus.hi, 32'd1); end
  endtask

  task automatic test_div_special();
    int cyc; logic d1, d2;
    run_op(4'd3, 32'd5, 32'd0, cyc, d1, d2);
    total++; if (bus.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_lo: got %h want %h", bus.lo, 32'hFFFF_FFFF); end
    total++; if (bus.hi !== 32'd5) begin bad++; $display("FAIL divz_hi: got %h want %h", bus.hi, 32'd5); end
    run_op(4'd3, 32'hFFFF_FFFB, 32'd0, cyc, d1, d2);
    total++; if (bus.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_neg_lo: got %h want %h", bus.lo, 32'hFFFF_FFFF); end
    total++; if (bus.hi !== 32'hFFFF_FFFB) begin bad++; $display("FAIL divz_neg_hi: got %h want %h", bus.hi, 32'hFFFF_FFFB); end
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, d1, d2);
    total++; if (bus.lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h want %h", bus.lo, 32'h8000_0000); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi: got %h want %h", bus.hi, 32'h0); end
  endtask

  task automatic test_madd();
    int cyc; logic d1, d2;
    write_hilo(1'b1, 1'b0, 32'h0);
    write_hilo(1'b0, 1'b1, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    run_op(4'd5, 32'd1, 32'd1, cyc, d1, d2);
    total++; if (cyc !== 5) begin bad++; $display("FAIL madd_busy_cycles: got %0d want 5", cyc); end
    total++; if (bus.hi !== 32'd1) begin bad++; $display("FAIL madd_hi: got %h want %h", bus.hi, 32'd1); end
    total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL madd_lo: got %h want %h", bus.lo, 32'd0); end
    run_op(4'd7, 32'd1, 32'd1, cyc, d1, d2);
    total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL msub_hi: got %h want %h", bus.hi, 32'd0); end
    total++; if (bus.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL msub_lo: got %h want %h", bus.lo, 32'hFFFF_FFFF); end
`else
    cyc = 0; d1 = 1'b0; d2 = 1'b0;
    bus.op = 4'd5; bus.w1 = 32'd1; bus.w2 = 32'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.op = 4'd0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL madd_off_busy: got %b want 0", bus.busy); end
    tick();
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL madd_off_hi: got %h want %h", bus.hi, 32'h0); end
    total++; if (bus.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL madd_off_lo: got %h want %h", bus.lo, 32'hFFFF_FFFF); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL madd_off_done: got %b want 0", bus.done); end
`endif
  endtask

  task automatic test_cancel();
    int cyc; logic d1, d2;
    write_hilo(1'b1, 1'b0, 32'h1111_1111);
    write_hilo(1'b0, 1'b1, 32'h2222_2222);
    bus.op = 4'd4; bus.w1 = 32'd100; bus.w2 = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.op = 4'd0;
    for (int i = 0; i < 9; i++) tick();
    total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL cancel_in_div: got %0d want 2", state_dbg); end
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL cancel_done: got %b want 0", bus.done); end
    total++; if (bus.hi !== 32'h1111_1111) begin bad++; $display("FAIL cancel_hi: got %h want %h", bus.hi, 32'h1111_1111); end
    total++; if (bus.lo !== 32'h2222_2222) begin bad++; $display("FAIL cancel_lo: got %h want %h", bus.lo, 32'h2222_2222); end
    run_op(4'd1, 32'd3, 32'd4, cyc, d1, d2);
    total++; if (cyc !== 5) begin bad++; $display("FAIL after_cancel_cycles: got %0d want 5", cyc); end
    total++; if (bus.lo !== 32'd12) begin bad++; $display("FAIL after_cancel_lo: got %h want %h", bus.lo, 32'd12); end
    total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL after_cancel_hi: got %h want %h", bus.hi, 32'd0); end
  endtask

  task automatic test_reset_mid_div();
    int cyc; logic d1, d2;
    write_hilo(1'b1, 1'b1, 32'hDEAD_BEEF);
    bus.op = 4'd3; bus.w1 = 32'd100; bus.w2 = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.op = 4'd0;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL async_rst_hi: got %h want %h", bus.hi, 32'h0); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL async_rst_lo: got %h want %h", bus.lo, 32'h0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_op(4'd4, 32'd100, 32'd7, cyc, d1, d2);
    total++; if (cyc !== 33) begin bad++; $display("FAIL post_rst_cycles: got %0d want 33", cyc); end
    total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL post_rst_lo: got %h want %h", bus.lo, 32'd14); end
    total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL post_rst_hi: got %h want %h", bus.hi, 32'd2); end
  endtask

  // sequence and report
  initial begin
    reset = 1'b0;
    bus.w1 = '0; bus.w2 = '0; bus.op = 4'd0;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.cancel = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_special();
    test_madd();
    test_cancel();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
